// File: rtl/seven_seg_reader.sv
// Reads back a multiplexed active-low 4-digit seven-segment bus and publishes 16-bit frames.
// Optional decimal-point capture is enabled by defining SEVEN_SEG_READER_DP_EN.
module seven_seg_reader #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
`ifdef SEVEN_SEG_READER_DP_EN
  input  logic        dp,
  output logic [3:0]  dp_out,
`endif
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_valid
);

`ifdef SEVEN_SEG_READER_DP_EN
  localparam int unsigned BusW = 8;
  logic [BusW-1:0] bus_raw;
  assign bus_raw = {dp, seg};
`else
  localparam int unsigned BusW = 7;
  logic [BusW-1:0] bus_raw;
  assign bus_raw = seg;
`endif

  typedef enum logic [1:0] {StWait, StSettle, StHold} state_e;

  // Returns {err, value}; unknown patterns decode to value 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic [BusW-1:0] bus_s1_q, bus_s2_q;
  logic [3:0]      an_s1_q, an_s2_q;
  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      mask_q, mask_d;
  logic [15:0]     sh_val_q, sh_val_d;
  logic [3:0]      sh_err_q, sh_err_d;
  logic [15:0]     digits_q;
  logic [3:0]      digit_err_q;
  logic            frame_valid_q;
  logic            change, an_onehot, capture, publish;
  logic [1:0]      idx;
  logic [4:0]      dec;
`ifdef SEVEN_SEG_READER_DP_EN
  logic [3:0]      sh_dp_q, sh_dp_d, dp_out_q;
`endif

  // The s1 stage is the value s2 takes on this edge, so counting and capture
  // act on the same edge that makes a new value visible as synchronized.
  always_comb begin
    change    = {an_s1_q, bus_s1_q} != {an_s2_q, bus_s2_q};
    an_onehot = $countones(~an_s1_q) == 1;
    cnt_d     = change ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
    dec       = decode(bus_s1_q[6:0]);
    idx       = '0;
    for (int i = 0; i < 4; i++) begin
      if (!an_s1_q[i]) idx = i[1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      StWait: if (an_onehot) state_d = StSettle;
      StSettle: begin
        if (!an_onehot) begin
          state_d = StWait;
        end else if (cnt_d == SETTLE_CYCLES[7:0]) begin
          capture = 1'b1;
          state_d = StHold;
        end
      end
      StHold: if (change) state_d = an_onehot ? StSettle : StWait;
      default: state_d = StWait;
    endcase
  end

  always_comb begin
    sh_val_d = sh_val_q;
    sh_err_d = sh_err_q;
    mask_d   = mask_q;
    publish  = 1'b0;
`ifdef SEVEN_SEG_READER_DP_EN
    sh_dp_d  = sh_dp_q;
`endif
    if (capture) begin
      sh_val_d[4*idx +: 4] = dec[3:0];
      sh_err_d[idx]        = dec[4];
      mask_d               = mask_q | (4'b0001 << idx);
`ifdef SEVEN_SEG_READER_DP_EN
      sh_dp_d[idx]         = ~bus_s1_q[7];
`endif
      if (mask_d == 4'hF) begin
        publish = 1'b1;
        mask_d  = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_s1_q      <= '1;
      bus_s2_q      <= '1;
      an_s1_q       <= '1;
      an_s2_q       <= '1;
      state_q       <= StWait;
      cnt_q         <= '0;
      mask_q        <= '0;
      sh_val_q      <= '0;
      sh_err_q      <= '0;
      digits_q      <= '0;
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
`ifdef SEVEN_SEG_READER_DP_EN
      sh_dp_q       <= '0;
      dp_out_q      <= '0;
`endif
    end else begin
      bus_s1_q      <= bus_raw;
      bus_s2_q      <= bus_s1_q;
      an_s1_q       <= an;
      an_s2_q       <= an_s1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      sh_val_q      <= sh_val_d;
      sh_err_q      <= sh_err_d;
      frame_valid_q <= publish;
      if (publish) begin
        digits_q    <= sh_val_d;
        digit_err_q <= sh_err_d;
      end
`ifdef SEVEN_SEG_READER_DP_EN
      sh_dp_q       <= sh_dp_d;
      if (publish) dp_out_q <= sh_dp_d;
`endif
    end
  end

  assign digits      = digits_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
`ifdef SEVEN_SEG_READER_DP_EN
  assign dp_out      = dp_out_q;
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench for seven_seg_reader: stimulus queues expected frames, a negedge monitor
// checks every frame_valid pulse and the reset state.
module tb_seven_seg_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;

  logic [19:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cycles = 0;
  logic        done   = 1'b0;

  seven_seg_reader #(.SETTLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .seg        (seg),
    .an         (an),
    .digits     (digits),
    .digit_err  (digit_err),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  // Called at a negedge; holds the bus for n rising edges.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    hold(4'b1111, 7'h7F, 6);
  endtask

  initial begin
    reset = 1'b1;
    an    = 4'b1111;
    seg   = 7'h7F;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle();

    // Basic scan: 3,1,6,F
    exp_q.push_back({16'hF613, 4'b0000});
    hold(4'b1110, 7'h30, 6);
    hold(4'b1101, 7'h79, 6);
    hold(4'b1011, 7'h02, 6);
    hold(4'b0111, 7'h0E, 6);
    idle();

    // Dwell of SETTLE_CYCLES-1 never captures
    hold(4'b1110, 7'h19, 3);
    hold(4'b1101, 7'h12, 3);
    hold(4'b1011, 7'h78, 3);
    hold(4'b0111, 7'h00, 3);
    idle();

    // Blank digit 2 flags an error and decodes to 0
    exp_q.push_back({16'h4020, 4'b0100});
    hold(4'b1110, 7'h40, 6);
    hold(4'b1101, 7'h24, 6);
    hold(4'b1011, 7'h7F, 6);
    hold(4'b0111, 7'h19, 6);
    idle();

    // Two anodes low is ignored; only the following scan completes a frame
    hold(4'b1100, 7'h00, 10);
    exp_q.push_back({16'h8765, 4'b0000});
    hold(4'b1110, 7'h12, 6);
    hold(4'b1101, 7'h02, 6);
    hold(4'b1011, 7'h78, 6);
    hold(4'b0111, 7'h00, 6);
    idle();

    // Recapture of digit 0 overwrites its slot without an extra frame
    exp_q.push_back({16'hCBA5, 4'b0000});
    hold(4'b1110, 7'h10, 6);
    hold(4'b1101, 7'h08, 6);
    hold(4'b1110, 7'h12, 6);
    hold(4'b1011, 7'h03, 6);
    hold(4'b0111, 7'h46, 6);
    idle();

    // Reset mid-frame: clears outputs between edges and discards partial mask
    hold(4'b1110, 7'h21, 6);
    hold(4'b1101, 7'h06, 6);
    hold(4'b1011, 7'h0E, 6);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle();
    hold(4'b0111, 7'h30, 6);
    idle();
    exp_q.push_back({16'h3321, 4'b0000});
    hold(4'b1110, 7'h79, 6);
    hold(4'b1101, 7'h24, 6);
    hold(4'b1011, 7'h30, 6);
    hold(4'b1111, 7'h7F, 8);
    done = 1'b1;
  end

  always @(negedge clk) begin
    logic [19:0] e;
    cycles++;
    if (reset) begin
      checks++;
      if (digits !== 16'h0 || digit_err !== 4'h0 || frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: got digits=%h err=%b fv=%b, need 0000/0000/0",
                 digits, digit_err, frame_valid);
      end
    end else if (frame_valid !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got digits=%h err=%b, need no frame",
                 digits, digit_err);
      end else begin
        e = exp_q.pop_front();
        if ({digits, digit_err} !== e) begin
          errors++;
          $display("FAIL frame: got digits=%h err=%b, need digits=%h err=%b",
                   digits, digit_err, e[19:4], e[3:0]);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_frame: got %0d frames outstanding, need 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (cycles > 5000) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles without completion, need <= 5000", cycles);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

endmodule
